// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, LSB first, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a0, b0, d, br_nx;

  assign a0    = a_sr[0];
  assign b0    = b_sr[0];
  assign d     = a0 ^ b0 ^ br;
  assign br_nx = (~a0 & b0) | (~(a0 ^ b0) & br);

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= in1;
            b_sr  <= in2;
            br    <= borrow_in;
            res   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nx;
          res  <= {d, res[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          // On the MSB cycle the outputs are loaded directly so they are valid in DONE.
          if (cnt == LAST) begin
            diff   <= {d, res[WIDTH-1:1]};
            borrow <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= (a0 ^ b0) & (a0 ^ d);
`endif
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8); hand-computed expected values.
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in1 = '0, in2 = '0;
  logic       borrow_in = 1'b0;
  logic       busy, done, borrow;
  logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
    .borrow_in(borrow_in), .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] ed, input logic eb, input logic eo);
    int n, nb;
    in1 = a; in2 = b; borrow_in = bi; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      tick();
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_lat"}, n, 8);
    check({tag, "_busycyc"}, nb, 8);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
    check({tag, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    if (eo) $display("note: %s expects ovf, feature not built", tag);
`endif
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, dones;
    #12 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_diff", {24'd0, diff}, 32'd0);
      check("idle_borrow", {31'd0, borrow}, 32'd0);
      tick();
    end

    run_op("basic",  8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
    run_op("neg",    8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
    run_op("wrap",   8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("equal",  8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("bin",    8'h40, 8'h10, 1'b1, 8'h2F, 1'b0, 1'b0);

    // start re-pulsed during SHIFT and DONE, operands changed after capture
    in1 = 8'h7F; in2 = 8'h01; borrow_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    in1 = 8'h00; in2 = 8'h55; borrow_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_diff", {24'd0, diff}, 32'h7E);
    check("ign_borrow", {31'd0, borrow}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      check("ign_busy_after", {31'd0, busy}, 32'd0);
      tick();
    end
    check("ign_extra_done", dones, 0);
    check("ign_diff_hold", {24'd0, diff}, 32'h7E);

    // reset mid-operation
    run_op("pre_rst", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
    in1 = 8'hAA; in2 = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_borrow", {31'd0, borrow}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    tick(); tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dones++;
      tick();
    end
    check("rst_no_done", dones, 0);
    run_op("post_rst", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    run_op("ovf_a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("ovf_b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("ovf_c", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
